// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory/MMIO slave: MMIO window base,
// register offsets, and TCTL bit positions.
package dmem_mmio_pkg;

  localparam logic [23:0] MMIO_BASE = 24'hFFFFFF;

  localparam logic [7:0] OFF_LED  = 8'h00;
  localparam logic [7:0] OFF_SW   = 8'h04;
  localparam logic [7:0] OFF_TCNT = 8'h08;
  localparam logic [7:0] OFF_TCMP = 8'h0C;
  localparam logic [7:0] OFF_TCTL = 8'h10;

  localparam int TCTL_EN   = 0;
  localparam int TCTL_AUTO = 1;
  localparam int TCTL_FLAG = 2;
  localparam int TCTL_IE   = 3;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:8] == MMIO_BASE;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU data-port bundle: address, store data, store strobe and load data.
// we is a single-cycle store strobe with no backpressure; rdata is valid in
// the same cycle as addr, so the slave never stalls the CPU.
interface dmem_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/dmem_mmio_timer.sv
// 32-bit compare timer: TCNT/TCMP/TCTL registers, match handling and irq.
// Match is evaluated on the pre-edge count; a TCNT write suppresses it.
module dmem_mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] wdata,
  input  logic        we_tcnt,
  input  logic        we_tcmp,
  input  logic        we_tctl,
  output logic [31:0] tcnt_rdata,
  output logic [31:0] tcmp_rdata,
  output logic [31:0] tctl_rdata,
  output logic        irq
);

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        flag_q, flag_d;
  logic        ie_q, ie_d;
  logic        hit;

  assign hit = en_q && (tcnt_q == tcmp_q) && !we_tcnt;

  always_comb begin
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    en_d   = en_q;
    auto_d = auto_q;
    flag_d = flag_q;
    ie_d   = ie_q;

    if (we_tcnt)     tcnt_d = wdata;
    else if (hit)    tcnt_d = auto_q ? 32'd0 : tcnt_q;
    else if (en_q)   tcnt_d = tcnt_q + 32'd1;

    if (we_tcmp) tcmp_d = wdata;

    if (hit && !auto_q) en_d = 1'b0;

    // Software TCTL write overrides the hardware EN clear; hardware FLAG set
    // overrides the software clear.
    if (we_tctl) begin
      en_d   = wdata[TCTL_EN];
      auto_d = wdata[TCTL_AUTO];
      ie_d   = wdata[TCTL_IE];
      if (wdata[TCTL_FLAG]) flag_d = 1'b0;
    end
    if (hit) flag_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= 32'd0;
      tcmp_q <= 32'hFFFF_FFFF;
      en_q   <= 1'b0;
      auto_q <= 1'b0;
      flag_q <= 1'b0;
      ie_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      en_q   <= en_d;
      auto_q <= auto_d;
      flag_q <= flag_d;
      ie_q   <= ie_d;
    end
  end

  always_comb begin
    tctl_rdata            = '0;
    tctl_rdata[TCTL_EN]   = en_q;
    tctl_rdata[TCTL_AUTO] = auto_q;
    tctl_rdata[TCTL_FLAG] = flag_q;
    tctl_rdata[TCTL_IE]   = ie_q;
  end

  assign tcnt_rdata = tcnt_q;
  assign tcmp_rdata = tcmp_q;
  assign irq        = flag_q & ie_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side slave of the single-cycle CPU: word RAM with async read, plus an
// MMIO window (LED, synchronised switches, compare timer) at 0xFFFFFFxx.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int LED_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  dmem_mmio_if.slave       bus,
  output logic [LED_W-1:0] led,
  input  logic [LED_W-1:0] sw,
  output logic             irq
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       ram_mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_ram;
  logic              sel_mmio;
  logic [7:0]        mmio_off;
  logic              we_ram, we_led, we_tcnt, we_tcmp, we_tctl;
  logic [LED_W-1:0]  led_q, led_d;
  logic [LED_W-1:0]  sw_meta_q, sw_meta_d;
  logic [LED_W-1:0]  sw_sync_q, sw_sync_d;
  logic [31:0]       tcnt_rdata, tcmp_rdata, tctl_rdata;
  logic              unused_byte_lane;

  // Byte lane bits are ignored; every access is a full word.
  assign unused_byte_lane = ^bus.addr[1:0];

  assign ram_idx  = bus.addr[RAM_AW+1:2];
  assign sel_ram  = ~bus.addr[31];
  assign sel_mmio = is_mmio(bus.addr);
  assign mmio_off = {bus.addr[7:2], 2'b00};

  always_comb begin
    we_ram  = bus.we && sel_ram;
    we_led  = bus.we && sel_mmio && (mmio_off == OFF_LED);
    we_tcnt = bus.we && sel_mmio && (mmio_off == OFF_TCNT);
    we_tcmp = bus.we && sel_mmio && (mmio_off == OFF_TCMP);
    we_tctl = bus.we && sel_mmio && (mmio_off == OFF_TCTL);
  end

  // RAM contents survive reset; only the write port is clocked.
  always_ff @(posedge clock) begin
    if (we_ram) ram_mem[ram_idx] <= bus.wdata;
  end

  always_comb begin
    led_d     = we_led ? bus.wdata[LED_W-1:0] : led_q;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  dmem_mmio_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .wdata      (bus.wdata),
    .we_tcnt    (we_tcnt),
    .we_tcmp    (we_tcmp),
    .we_tctl    (we_tctl),
    .tcnt_rdata (tcnt_rdata),
    .tcmp_rdata (tcmp_rdata),
    .tctl_rdata (tctl_rdata),
    .irq        (irq)
  );

  always_comb begin
    bus.rdata = '0;
    if (sel_ram) begin
      bus.rdata = ram_mem[ram_idx];
    end else if (sel_mmio) begin
      case (mmio_off)
        OFF_LED:  bus.rdata = 32'(led_q);
        OFF_SW:   bus.rdata = 32'(sw_sync_q);
        OFF_TCNT: bus.rdata = tcnt_rdata;
        OFF_TCMP: bus.rdata = tcmp_rdata;
        OFF_TCTL: bus.rdata = tctl_rdata;
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed plus randomised bench for dmem_mmio against a behavioural model of
// the memory map, switch pipeline and compare timer.
module tb_dmem_mmio;

  localparam int RAM_AW = 8;
  localparam int LED_W  = 16;
  localparam logic [31:0] A_LED  = 32'hFFFF_FF00;
  localparam logic [31:0] A_SW   = 32'hFFFF_FF04;
  localparam logic [31:0] A_TCNT = 32'hFFFF_FF08;
  localparam logic [31:0] A_TCMP = 32'hFFFF_FF0C;
  localparam logic [31:0] A_TCTL = 32'hFFFF_FF10;

  // ---------------- clock / reset ----------------
  logic             clock;
  logic             reset_n;
  logic [LED_W-1:0] led;
  logic [LED_W-1:0] sw;
  logic             irq;

  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_AW(RAM_AW), .LED_W(LED_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .led     (led),
    .sw      (sw),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_ram [0:255];
  logic [15:0] m_led;
  logic [15:0] sw_hist[$];
  logic [31:0] m_tcnt, m_tcmp;
  logic        m_en, m_auto, m_flag, m_ie;

  task automatic model_reset();
    m_led   = '0;
    m_tcnt  = '0;
    m_tcmp  = 32'hFFFF_FFFF;
    m_en    = 1'b0;
    m_auto  = 1'b0;
    m_flag  = 1'b0;
    m_ie    = 1'b0;
    sw_hist = '{16'h0, 16'h0};
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (!a[31]) return m_ram[a[9:2]];
    if (a[31:8] != 24'hFFFFFF) return 32'h0;
    case (a[7:2])
      6'd0:    return {16'h0, m_led};
      6'd1:    return {16'h0, sw_hist[0]};
      6'd2:    return m_tcnt;
      6'd3:    return m_tcmp;
      6'd4:    return {28'h0, m_ie, m_flag, m_auto, m_en};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One rising edge: model the edge from pre-edge inputs/state, then commit.
  task automatic tick();
    logic [31:0] a, d, n_tcnt;
    logic        we_now, mm, w_led, w_tcnt, w_tcmp, w_tctl, hit, n_en, n_flag;
    logic [15:0] sw_now;
    a = bus.addr; d = bus.wdata; we_now = bus.we; sw_now = sw;
    mm     = we_now && (a[31:8] == 24'hFFFFFF);
    w_led  = mm && (a[7:2] == 6'd0);
    w_tcnt = mm && (a[7:2] == 6'd2);
    w_tcmp = mm && (a[7:2] == 6'd3);
    w_tctl = mm && (a[7:2] == 6'd4);
    hit    = m_en && (m_tcnt == m_tcmp) && !w_tcnt;
    if (w_tcnt)      n_tcnt = d;
    else if (hit)    n_tcnt = m_auto ? 32'h0 : m_tcnt;
    else if (m_en)   n_tcnt = m_tcnt + 32'h1;
    else             n_tcnt = m_tcnt;
    n_en = m_en;
    if (hit && !m_auto) n_en = 1'b0;
    if (w_tctl) n_en = d[0];
    n_flag = (w_tctl && d[2]) ? 1'b0 : m_flag;
    if (hit) n_flag = 1'b1;
    @(posedge clock);
    if (we_now && !a[31]) m_ram[a[9:2]] = d;
    if (w_led)  m_led = d[15:0];
    if (w_tcmp) m_tcmp = d;
    if (w_tctl) begin m_auto = d[1]; m_ie = d[3]; end
    m_tcnt = n_tcnt; m_en = n_en; m_flag = n_flag;
    sw_hist.push_back(sw_now);
    void'(sw_hist.pop_front());
    #1;
  endtask

  task automatic idle(input int n);
    bus.we = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a; bus.we = 1'b0;
    #1;
    v = bus.rdata;
  endtask

  task automatic rd_lit(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, mread(a));
  endtask

  task automatic state_chk(input string tag);
    check({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, m_flag & m_ie});
    rd_chk({tag, "_sw"},   A_SW);
    rd_chk({tag, "_tcnt"}, A_TCNT);
    rd_chk({tag, "_tcmp"}, A_TCMP);
    rd_chk({tag, "_tctl"}, A_TCTL);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return {22'h0, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      1:       return {1'b0, 31'($urandom)};
      2, 3:    return {24'hFFFFFF, 3'b000, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      4:       return {24'hFFFFFF, 8'($urandom)};
      default: return {1'b1, 31'($urandom)};
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a;
    reset_n   = 1'b0;
    sw        = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;

    // reset state
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd_lit("rst_tcnt", A_TCNT, 32'h0);
    rd_lit("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd_lit("rst_tctl", A_TCTL, 32'h0);
    rd_lit("rst_sw",   A_SW,   32'h0);
    #1 reset_n = 1'b1;

    // give every RAM word a known value
    for (int i = 0; i < 256; i++) wr(32'(i * 4), 32'h0);

    // RAM store/load, byte-lane and alias
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_lit("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_lit("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd_lit("ram_14", 32'h0000_0014, 32'h0);
    rd_lit("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);

    // LED and switch synchroniser
    wr(A_LED, 32'h0000_A5A5);
    check("led_out", {16'h0, led}, 32'h0000_A5A5);
    rd_lit("led_rd", A_LED, 32'h0000_A5A5);
    wr(A_LED, 32'hFFFF_1234);
    rd_lit("led_upper", A_LED, 32'h0000_1234);
    sw = 16'h1234;
    idle(1);
    rd_lit("sw_1edge", A_SW, 32'h0);
    idle(1);
    rd_lit("sw_2edge", A_SW, 32'h0000_1234);
    wr(A_SW, 32'h0000_FFFF);
    rd_lit("sw_ro", A_SW, 32'h0000_1234);

    // one-shot timer
    wr(A_TCMP, 32'd5);
    wr(A_TCTL, 32'h9);
    idle(5);
    check("os_irq_pre", {31'h0, irq}, 32'h0);
    idle(1);
    check("os_irq", {31'h0, irq}, 32'h1);
    rd_lit("os_tcnt", A_TCNT, 32'd5);
    rd_lit("os_tctl", A_TCTL, 32'hC);
    wr(A_TCTL, 32'h4);
    check("os_clr_irq", {31'h0, irq}, 32'h0);
    rd_lit("os_clr_tctl", A_TCTL, 32'h0);
    state_chk("os");

    // auto-reload timer, W1C racing a match
    wr(A_TCNT, 32'd0);
    wr(A_TCMP, 32'd3);
    wr(A_TCTL, 32'h3);
    idle(4);
    rd_lit("ar_tcnt", A_TCNT, 32'd0);
    rd_lit("ar_tctl", A_TCTL, 32'h7);
    idle(3);
    wr(A_TCTL, 32'h7);
    rd_lit("ar_race_tctl", A_TCTL, 32'h7);
    rd_lit("ar_race_tcnt", A_TCNT, 32'd0);
    wr(A_TCTL, 32'h7);
    rd_lit("ar_w1c_tctl", A_TCTL, 32'h3);
    rd_lit("ar_w1c_tcnt", A_TCNT, 32'd1);

    // write priority and wrap
    wr(A_TCMP, 32'd10);
    wr(A_TCNT, 32'hFFFF_FFFF);
    rd_lit("wrap_load", A_TCNT, 32'hFFFF_FFFF);
    idle(1);
    rd_lit("wrap_tcnt", A_TCNT, 32'd0);
    rd_lit("wrap_tctl", A_TCTL, 32'h3);
    wr(A_TCNT, 32'd100);
    rd_lit("prio_load", A_TCNT, 32'd100);
    idle(1);
    rd_lit("prio_count", A_TCNT, 32'd101);

    // software EN write wins over one-shot stop on the same edge
    wr(A_TCTL, 32'h1);
    wr(A_TCMP, 32'd104);
    idle(1);
    rd_lit("enwin_pre", A_TCNT, 32'd104);
    wr(A_TCTL, 32'h1);
    rd_lit("enwin_tctl", A_TCTL, 32'h5);
    rd_lit("enwin_tcnt", A_TCNT, 32'd104);
    idle(1);
    rd_lit("enwin_stop", A_TCTL, 32'h4);
    state_chk("enwin");

    // reset in the middle of counting
    wr(A_TCTL, 32'hF);
    wr(A_TCNT, 32'd0);
    wr(A_TCMP, 32'd2);
    for (int i = 0; i < 20 && !m_flag; i++) tick();
    check("mid_irq_set", {31'h0, irq}, 32'h1);
    idle(1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_led", {16'h0, led}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rd_lit("mid_rst_tcnt", A_TCNT, 32'h0);
    rd_lit("mid_rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd_lit("mid_rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    #1 reset_n = 1'b1;

    // unmapped accesses
    wr(A_LED, 32'h0000_00C3);
    rd_lit("unm_rd_hi", 32'h8000_0000, 32'h0);
    rd_lit("unm_rd_mmio", 32'hFFFF_FF20, 32'h0);
    rd_lit("unm_rd_14", 32'hFFFF_FF14, 32'h0);
    wr(32'h8000_0000, 32'hCAFE_F00D);
    wr(32'hFFFF_FF20, 32'hFFFF_FFFF);
    rd_lit("unm_ram0", 32'h0000_0000, 32'h0);
    check("unm_led", {16'h0, led}, 32'h0000_00C3);
    state_chk("unm");

    // randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      a = rand_addr();
      bus.addr  = a;
      bus.wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12)) : $urandom;
      bus.we    = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      tick();
      bus.we = 1'b0;
      check("rnd_led", {16'h0, led}, {16'h0, m_led});
      check("rnd_irq", {31'h0, irq}, {31'h0, m_flag & m_ie});
      rd_chk("rnd_same", a);
      rd_chk("rnd_any", rand_addr());
    end
    state_chk("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
